vote_display_ctrl: RTL and testbench

Parametrised LED/display controller for the voting machine, successor to the fixed four-candidate mode controller. It sits between the vote counter bank and the board LEDs. In voting mode it stretches each accepted vote into a visible flash. In result mode it shows any candidate's live count, selected by button or by timed auto-scan, and continuously reports the current leader and tie status.

---
 rtl/vote_pkg.sv | 14 +
 rtl/vote_leader_find.sv | 32 +++
 rtl/vote_display_ctrl.sv | 125 ++++++++++++
 tb/tb_vote_display_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared definitions for the voting machine: display FSM states and the
// default candidate/count sizing used by the counter bank and display.
package vote_pkg;

  typedef enum logic [1:0] {
    VOTE_IDLE,
    VOTE_FLASH,
    RESULT
  } disp_state_t;

  localparam int unsigned DEF_NUM_CANDIDATES = 4;
  localparam int unsigned DEF_COUNT_W        = 8;

endpackage

// File: rtl/vote_leader_find.sv
// Combinational argmax over the packed count bus: lowest index holding the
// maximum, plus a flag when that maximum is shared.
module vote_leader_find #(
  parameter int unsigned NUM_CANDIDATES = vote_pkg::DEF_NUM_CANDIDATES,
  parameter int unsigned COUNT_W        = vote_pkg::DEF_COUNT_W,
  parameter int unsigned IDX_W          = $clog2(NUM_CANDIDATES)
) (
  input  logic [NUM_CANDIDATES*COUNT_W-1:0] counts,
  output logic [IDX_W-1:0]                  leader_idx,
  output logic                              tie
);

  logic [COUNT_W-1:0] max_val;

  // A strictly greater count clears any tie seen so far; equality keeps the
  // earlier (lower) index as leader.
  always_comb begin
    max_val    = counts[COUNT_W-1:0];
    leader_idx = '0;
    tie        = 1'b0;
    for (int unsigned i = 1; i < NUM_CANDIDATES; i++) begin
      if (counts[i*COUNT_W +: COUNT_W] > max_val) begin
        max_val    = counts[i*COUNT_W +: COUNT_W];
        leader_idx = IDX_W'(i);
        tie        = 1'b0;
      end else if (counts[i*COUNT_W +: COUNT_W] == max_val) begin
        tie = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vote_display_ctrl.sv
// LED/display controller: vote flash stretching in voting mode, selectable or
// auto-scanned count display in result mode, and registered leader/tie report.
module vote_display_ctrl #(
  parameter int unsigned NUM_CANDIDATES = vote_pkg::DEF_NUM_CANDIDATES,
  parameter int unsigned COUNT_W        = vote_pkg::DEF_COUNT_W,
  parameter int unsigned FLASH_CYCLES   = 50_000_000,
  parameter int unsigned SCAN_CYCLES    = 100_000_000,
  parameter int unsigned IDX_W          = $clog2(NUM_CANDIDATES)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              mode,
  input  logic                              valid_vote_casted,
  input  logic [NUM_CANDIDATES*COUNT_W-1:0] candidate_votes,
  input  logic [NUM_CANDIDATES-1:0]         candidate_button_press,
  input  logic                              scan_enable,
  output logic [COUNT_W-1:0]                leds,
  output logic [IDX_W-1:0]                  selected_idx,
  output logic [IDX_W-1:0]                  leader_idx,
  output logic                              tie
);
  import vote_pkg::*;

  localparam int unsigned FLASH_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam int unsigned SCAN_W  = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_CYCLES - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_CANDIDATES - 1);

  disp_state_t        state, state_n;
  logic [FLASH_W-1:0] flash_cnt, flash_cnt_n;
  logic [SCAN_W-1:0]  scan_cnt, scan_cnt_n;
  logic [IDX_W-1:0]   sel_n, press_idx, lead_c;
  logic               press_any, tie_c;
  logic [COUNT_W-1:0] sel_count, leds_n;

  vote_leader_find #(
    .NUM_CANDIDATES (NUM_CANDIDATES),
    .COUNT_W        (COUNT_W),
    .IDX_W          (IDX_W)
  ) u_leader (
    .counts     (candidate_votes),
    .leader_idx (lead_c),
    .tie        (tie_c)
  );

  always_comb begin
    press_idx = '0;
    press_any = 1'b0;
    for (int unsigned i = 0; i < NUM_CANDIDATES; i++) begin
      if (candidate_button_press[i] && !press_any) begin
        press_idx = IDX_W'(i);
        press_any = 1'b1;
      end
    end
  end

  // Mode wins over vote strobes; entering RESULT resets selection and timers
  // and ignores any press landing on the entry cycle.
  always_comb begin
    state_n     = state;
    flash_cnt_n = flash_cnt;
    scan_cnt_n  = scan_cnt;
    sel_n       = selected_idx;
    if (mode) begin
      state_n = RESULT;
      if (state != RESULT) begin
        sel_n       = '0;
        scan_cnt_n  = '0;
        flash_cnt_n = '0;
      end else if (press_any) begin
        sel_n      = press_idx;
        scan_cnt_n = '0;
      end else if (scan_enable) begin
        if (scan_cnt == SCAN_LAST) begin
          scan_cnt_n = '0;
          sel_n      = (selected_idx == IDX_LAST) ? '0 : selected_idx + 1'b1;
        end else begin
          scan_cnt_n = scan_cnt + 1'b1;
        end
      end
    end else if (valid_vote_casted) begin
      state_n     = VOTE_FLASH;
      flash_cnt_n = FLASH_LOAD;
    end else if (state == VOTE_FLASH) begin
      if (flash_cnt == '0) state_n = VOTE_IDLE;
      else                 flash_cnt_n = flash_cnt - 1'b1;
    end else begin
      state_n = VOTE_IDLE;
    end
  end

  always_comb begin
    sel_count = '0;
    for (int unsigned i = 0; i < NUM_CANDIDATES; i++) begin
      if (sel_n == IDX_W'(i)) sel_count = candidate_votes[i*COUNT_W +: COUNT_W];
    end
    case (state_n)
      VOTE_FLASH: leds_n = '1;
      RESULT:     leds_n = sel_count;
      default:    leds_n = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= VOTE_IDLE;
      flash_cnt    <= '0;
      scan_cnt     <= '0;
      selected_idx <= '0;
      leds         <= '0;
      leader_idx   <= '0;
      tie          <= 1'b0;
    end else begin
      state        <= state_n;
      flash_cnt    <= flash_cnt_n;
      scan_cnt     <= scan_cnt_n;
      selected_idx <= sel_n;
      leds         <= leds_n;
      leader_idx   <= lead_c;
      tie          <= tie_c;
    end
  end

endmodule

// File: tb/tb_vote_display_ctrl.sv
// Scoreboard bench for vote_display_ctrl: a cycle-level behavioural model
// predicts every output sample; a negedge monitor compares the DUT against it.
module tb_vote_display_ctrl;

  localparam int N     = 4;
  localparam int CW    = 8;
  localparam int FLASH = 3;
  localparam int SCAN  = 4;

  logic          clock;
  logic          reset;
  logic          mode;
  logic          valid_vote_casted;
  logic [N*CW-1:0] candidate_votes;
  logic [N-1:0]  candidate_button_press;
  logic          scan_enable;
  logic [CW-1:0] leds;
  logic [1:0]    selected_idx;
  logic [1:0]    leader_idx;
  logic          tie;

  vote_display_ctrl #(
    .NUM_CANDIDATES (N),
    .COUNT_W        (CW),
    .FLASH_CYCLES   (FLASH),
    .SCAN_CYCLES    (SCAN)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .mode                   (mode),
    .valid_vote_casted      (valid_vote_casted),
    .candidate_votes        (candidate_votes),
    .candidate_button_press (candidate_button_press),
    .scan_enable            (scan_enable),
    .leds                   (leds),
    .selected_idx           (selected_idx),
    .leader_idx             (leader_idx),
    .tie                    (tie)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int unsigned leds;
    int unsigned sel;
    int unsigned lead;
    int unsigned tie;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state, in terms of time and events rather than counters.
  longint edge_no     = 0;
  longint flash_until = -1;  // last edge number at which the flash is shown
  bit     m_result    = 0;
  int     m_sel       = 0;
  int     m_ticks     = 0;   // enabled scan edges since last selection event

  function automatic int count_of(input logic [N*CW-1:0] cv, input int i);
    return int'(cv[i*CW +: CW]);
  endfunction

  task automatic model_step();
    exp_t e;
    int   mx, nmax, lead, lo;
    edge_no++;
    if (reset) begin
      flash_until = -1;
      m_result    = 0;
      m_sel       = 0;
      m_ticks     = 0;
      e.leds = 0; e.sel = 0; e.lead = 0; e.tie = 0;
    end else begin
      mx = -1;
      for (int i = 0; i < N; i++) if (count_of(candidate_votes, i) > mx) mx = count_of(candidate_votes, i);
      nmax = 0; lead = -1;
      for (int i = 0; i < N; i++) begin
        if (count_of(candidate_votes, i) == mx) begin
          nmax++;
          if (lead < 0) lead = i;
        end
      end
      if (mode) begin
        flash_until = -1;
        if (!m_result) begin
          m_sel = 0; m_ticks = 0;
        end else if (candidate_button_press != '0) begin
          lo = -1;
          for (int i = 0; i < N; i++) if (candidate_button_press[i] && lo < 0) lo = i;
          m_sel = lo; m_ticks = 0;
        end else if (scan_enable) begin
          m_ticks++;
          if (m_ticks == SCAN) begin
            m_sel   = (m_sel + 1) % N;
            m_ticks = 0;
          end
        end
        e.leds = count_of(candidate_votes, m_sel);
      end else begin
        if (valid_vote_casted) flash_until = edge_no + FLASH - 1;
        e.leds = (edge_no <= flash_until) ? 255 : 0;
      end
      m_result = mode;
      e.sel  = m_sel;
      e.lead = lead;
      e.tie  = (nmax > 1) ? 1 : 0;
    end
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    exp_t e;
    @(negedge clock);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty at %0t: no expected entry, got leds=%0d", $time, leds);
    end else begin
      e = exp_q.pop_front();
      if (int'(leds) != e.leds) begin
        n_fail++;
        $display("FAIL leds at %0t: got %0d expected %0d", $time, leds, e.leds);
      end
      n_checks++;
      if (int'(selected_idx) != e.sel) begin
        n_fail++;
        $display("FAIL selected_idx at %0t: got %0d expected %0d", $time, selected_idx, e.sel);
      end
      n_checks++;
      if (int'(leader_idx) != e.lead) begin
        n_fail++;
        $display("FAIL leader_idx at %0t: got %0d expected %0d", $time, leader_idx, e.lead);
      end
      n_checks++;
      if (int'(tie) != e.tie) begin
        n_fail++;
        $display("FAIL tie at %0t: got %0d expected %0d", $time, tie, e.tie);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic set_counts(input int c0, input int c1, input int c2, input int c3);
    candidate_votes = {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
  endtask

  task automatic vote_pulse();
    valid_vote_casted = 1'b1;
    step(1);
    valid_vote_casted = 1'b0;
  endtask

  task automatic press_pulse(input logic [N-1:0] p);
    candidate_button_press = p;
    step(1);
    candidate_button_press = '0;
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; valid_vote_casted = 1'b0;
    candidate_votes = '0; candidate_button_press = '0; scan_enable = 1'b0;
    step(2);
    reset = 1'b0;
    step(2);

    // Single flash, then overlapping strobes extending it.
    vote_pulse(); step(5);
    vote_pulse(); step(1); vote_pulse(); step(6);

    // Result display, button selection, live count tracking.
    set_counts(9, 5, 7, 3);
    mode = 1'b1; step(2);
    press_pulse(4'b0100); step(1);
    press_pulse(4'b1010); step(1);
    set_counts(9, 6, 7, 3); step(2);

    // Auto-scan with wrap, press mid-interval, freeze.
    scan_enable = 1'b1; step(18);
    step(2); press_pulse(4'b1000); step(8);
    scan_enable = 1'b0; step(3);
    scan_enable = 1'b1; step(5);

    // Leader and tie tracking in voting mode.
    mode = 1'b0; scan_enable = 1'b0;
    set_counts(4, 9, 9, 2); step(2);
    set_counts(4, 9, 10, 2); step(2);
    set_counts(0, 0, 0, 0); step(2);

    // Reset mid-flash and mid-scan; vote strobe in result mode.
    vote_pulse(); step(1);
    reset = 1'b1; step(1); reset = 1'b0; step(2);
    set_counts(1, 2, 3, 4);
    mode = 1'b1; scan_enable = 1'b1; step(6);
    reset = 1'b1; step(1); reset = 1'b0; step(2);
    vote_pulse(); step(3);

    // Leaving result with a vote on the same cycle.
    mode = 1'b0; valid_vote_casted = 1'b1; step(1);
    valid_vote_casted = 1'b0; step(5);

    // Randomized phase.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 9) == 0) scan_enable = ~scan_enable;
      valid_vote_casted = ($urandom_range(0, 4) == 0);
      candidate_button_press = ($urandom_range(0, 7) == 0) ? N'($urandom_range(1, 15)) : '0;
      if ($urandom_range(0, 3) == 0) begin
        int idx;
        idx = $urandom_range(0, N - 1);
        candidate_votes[idx*CW +: CW] = ($urandom_range(0, 5) == 0) ? CW'($urandom_range(0, 255))
                                                                     : CW'($urandom_range(0, 3));
      end
      reset = ($urandom_range(0, 99) == 0);
      step(1);
    end
    reset = 1'b0; valid_vote_casted = 1'b0; candidate_button_press = '0;
    step(3);
    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
